// File: rtl/proj1_pkg.sv
// Shared definitions for the display conversion path: digit geometry and
// the state encodings used by the time-shared BCD converter.
package proj1_pkg;

    localparam int DIGIT_W   = 4;
    localparam int C_DIGITS  = 4;
    localparam int AB_DIGITS = 2;

    // Width of the shared BCD shift register and of one operand slot.
    localparam int BCD_W    = C_DIGITS * DIGIT_W;
    localparam int AB_BCD_W = AB_DIGITS * DIGIT_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_STORE
    } state_e;

    // Operand currently owning the conversion engine.
    typedef enum logic [1:0] {
        SEL_A,
        SEL_B,
        SEL_C
    } sel_e;

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: every BCD nibble of 5 or more gets 3 added,
// then the whole register shifts left taking in the next magnitude bit.
module bcd_dd_step
    import proj1_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    input  logic             bit_i,
    output logic [BCD_W-1:0] bcd_o
);

    logic [BCD_W-1:0] adjusted;

    // Correct each digit so the following shift carries properly into the next decade.
    always_comb begin
        adjusted = bcd_i;
        for (int i = 0; i < C_DIGITS; i++) begin
            if (bcd_i[i*DIGIT_W +: DIGIT_W] >= DIGIT_W'(5)) begin
                adjusted[i*DIGIT_W +: DIGIT_W] = bcd_i[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(3);
            end
        end
        bcd_o = {adjusted[BCD_W-2:0], bit_i};
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// Time-shared binary-to-BCD converter for the display: snapshots operand a,
// operand b and ALU result c, converts them one after another through a single
// double-dabble engine, and publishes all digits and signs on one edge.
module bcd_conv_sched
    import proj1_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int CWIDTH = 12,
    parameter bit AUTO   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                refresh_i,
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    input  logic [CWIDTH-1:0]   c_i,
    input  logic                c_err_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [AB_BCD_W-1:0] a_bcd_o,
    output logic                a_neg_o,
    output logic [AB_BCD_W-1:0] b_bcd_o,
    output logic                b_neg_o,
    output logic [BCD_W-1:0]    c_bcd_o,
    output logic                c_neg_o,
    output logic                err_o
);

    localparam int CNT_W = $clog2(CWIDTH + 1);

    state_e              state_q, state_d;
    sel_e                sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CWIDTH-1:0]   shiftReg_q, shiftReg_d;
    logic [BCD_W-1:0]    bcdReg_q, bcdReg_d;
    logic [WIDTH-1:0]    bMag_q, bMag_d;
    logic [CWIDTH-1:0]   cMag_q, cMag_d;
    logic                aSign_q, aSign_d;
    logic                bSign_q, bSign_d;
    logic                cSign_q, cSign_d;
    logic                errSnap_q, errSnap_d;
    logic [AB_BCD_W-1:0] stageA_q, stageA_d;
    logic [AB_BCD_W-1:0] stageB_q, stageB_d;
    logic [AB_BCD_W-1:0] aBcdPub_q, aBcdPub_d;
    logic [AB_BCD_W-1:0] bBcdPub_q, bBcdPub_d;
    logic [BCD_W-1:0]    cBcdPub_q, cBcdPub_d;
    logic                aNegPub_q, aNegPub_d;
    logic                bNegPub_q, bNegPub_d;
    logic                cNegPub_q, cNegPub_d;
    logic                errPub_q, errPub_d;
    logic                done_q, done_d;

    logic [BCD_W-1:0]    ddNext;
    logic [WIDTH-1:0]    absA, absB;
    logic [CWIDTH-1:0]   absC;

    // Two's-complement magnitudes; the most-negative value maps to its unsigned bit pattern.
    assign absA = a_i[WIDTH-1]  ? -a_i : a_i;
    assign absB = b_i[WIDTH-1]  ? -b_i : b_i;
    assign absC = c_i[CWIDTH-1] ? -c_i : c_i;

    bcd_dd_step u_step (
        .bcd_i (bcdReg_q),
        .bit_i (shiftReg_q[CWIDTH-1]),
        .bcd_o (ddNext)
    );

    // Sequencer and datapath next-state: snapshot, convert a, b, c in turn, then publish together.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        shiftReg_d = shiftReg_q;
        bcdReg_d   = bcdReg_q;
        bMag_d     = bMag_q;
        cMag_d     = cMag_q;
        aSign_d    = aSign_q;
        bSign_d    = bSign_q;
        cSign_d    = cSign_q;
        errSnap_d  = errSnap_q;
        stageA_d   = stageA_q;
        stageB_d   = stageB_q;
        aBcdPub_d  = aBcdPub_q;
        bBcdPub_d  = bBcdPub_q;
        cBcdPub_d  = cBcdPub_q;
        aNegPub_d  = aNegPub_q;
        bNegPub_d  = bNegPub_q;
        cNegPub_d  = cNegPub_q;
        errPub_d   = errPub_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (refresh_i || AUTO) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                aSign_d    = a_i[WIDTH-1];
                bSign_d    = b_i[WIDTH-1];
                cSign_d    = c_i[CWIDTH-1];
                errSnap_d  = c_err_i;
                bMag_d     = absB;
                cMag_d     = absC;
                shiftReg_d = CWIDTH'(absA) << (CWIDTH - WIDTH);
                sel_d      = SEL_A;
                bcdReg_d   = '0;
                cnt_d      = CNT_W'(WIDTH);
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                bcdReg_d   = ddNext;
                shiftReg_d = {shiftReg_q[CWIDTH-2:0], 1'b0};
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                bcdReg_d = '0;
                case (sel_q)
                    SEL_A: begin
                        stageA_d   = bcdReg_q[AB_BCD_W-1:0];
                        sel_d      = SEL_B;
                        shiftReg_d = CWIDTH'(bMag_q) << (CWIDTH - WIDTH);
                        cnt_d      = CNT_W'(WIDTH);
                        state_d    = ST_SHIFT;
                    end
                    SEL_B: begin
                        stageB_d   = bcdReg_q[AB_BCD_W-1:0];
                        sel_d      = SEL_C;
                        shiftReg_d = cMag_q;
                        cnt_d      = CNT_W'(CWIDTH);
                        state_d    = ST_SHIFT;
                    end
                    default: begin
                        aBcdPub_d = stageA_q;
                        bBcdPub_d = stageB_q;
                        cBcdPub_d = bcdReg_q;
                        aNegPub_d = aSign_q;
                        bNegPub_d = bSign_q;
                        cNegPub_d = cSign_q;
                        errPub_d  = errSnap_q;
                        done_d    = 1'b1;
                        state_d   = AUTO ? ST_LOAD : ST_IDLE;
                    end
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state registers; reset clears everything, including a pass already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_A;
            cnt_q      <= '0;
            shiftReg_q <= '0;
            bcdReg_q   <= '0;
            bMag_q     <= '0;
            cMag_q     <= '0;
            aSign_q    <= 1'b0;
            bSign_q    <= 1'b0;
            cSign_q    <= 1'b0;
            errSnap_q  <= 1'b0;
            stageA_q   <= '0;
            stageB_q   <= '0;
            aBcdPub_q  <= '0;
            bBcdPub_q  <= '0;
            cBcdPub_q  <= '0;
            aNegPub_q  <= 1'b0;
            bNegPub_q  <= 1'b0;
            cNegPub_q  <= 1'b0;
            errPub_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            shiftReg_q <= shiftReg_d;
            bcdReg_q   <= bcdReg_d;
            bMag_q     <= bMag_d;
            cMag_q     <= cMag_d;
            aSign_q    <= aSign_d;
            bSign_q    <= bSign_d;
            cSign_q    <= cSign_d;
            errSnap_q  <= errSnap_d;
            stageA_q   <= stageA_d;
            stageB_q   <= stageB_d;
            aBcdPub_q  <= aBcdPub_d;
            bBcdPub_q  <= bBcdPub_d;
            cBcdPub_q  <= cBcdPub_d;
            aNegPub_q  <= aNegPub_d;
            bNegPub_q  <= bNegPub_d;
            cNegPub_q  <= cNegPub_d;
            errPub_q   <= errPub_d;
            done_q     <= done_d;
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = done_q;
    assign a_bcd_o = aBcdPub_q;
    assign a_neg_o = aNegPub_q;
    assign b_bcd_o = bBcdPub_q;
    assign b_neg_o = bNegPub_q;
    assign c_bcd_o = cBcdPub_q;
    assign c_neg_o = cNegPub_q;
    assign err_o   = errPub_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for bcd_conv_sched: table of input/expected-digit records driven through
// a scoreboard, plus sequences for mid-pass refresh, mid-pass reset, held refresh
// and a free-running AUTO instance.
module tb_bcd_conv_sched;

    typedef struct {
        logic [7:0]  aBcd;
        logic        aNeg;
        logic [7:0]  bBcd;
        logic        bNeg;
        logic [15:0] cBcd;
        logic        cNeg;
        logic        err;
    } exp_t;

    typedef struct {
        logic [5:0]  a;
        logic [5:0]  b;
        logic [11:0] c;
        logic        cErr;
        exp_t        e;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        refresh;
    logic [5:0]  a, b;
    logic [11:0] c;
    logic        cErr;
    logic        busy, done;
    logic [7:0]  aBcd, bBcd;
    logic [15:0] cBcd;
    logic        aNeg, bNeg, cNeg, err;

    logic [5:0]  autoA, autoB;
    logic [11:0] autoC;
    logic        autoCErr;
    logic        autoBusy, autoDone;
    logic [7:0]  autoABcd, autoBBcd;
    logic [15:0] autoCBcd;
    logic        autoANeg, autoBNeg, autoCNeg, autoErr;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[7];

    bcd_conv_sched #(.WIDTH(6), .CWIDTH(12), .AUTO(1'b0)) dut (
        .clk(clk), .rst(rst), .refresh_i(refresh),
        .a_i(a), .b_i(b), .c_i(c), .c_err_i(cErr),
        .busy_o(busy), .done_o(done),
        .a_bcd_o(aBcd), .a_neg_o(aNeg), .b_bcd_o(bBcd), .b_neg_o(bNeg),
        .c_bcd_o(cBcd), .c_neg_o(cNeg), .err_o(err)
    );

    bcd_conv_sched #(.WIDTH(6), .CWIDTH(12), .AUTO(1'b1)) dutAuto (
        .clk(clk), .rst(rst), .refresh_i(1'b0),
        .a_i(autoA), .b_i(autoB), .c_i(autoC), .c_err_i(autoCErr),
        .busy_o(autoBusy), .done_o(autoDone),
        .a_bcd_o(autoABcd), .a_neg_o(autoANeg), .b_bcd_o(autoBBcd), .b_neg_o(autoBNeg),
        .c_bcd_o(autoCBcd), .c_neg_o(autoCNeg), .err_o(autoErr)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one vector with a single-cycle refresh and records the expected result.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        a       = v.a;
        b       = v.b;
        c       = v.c;
        cErr    = v.cErr;
        refresh = 1'b1;
        @(posedge clk);
        #1;
        refresh = 1'b0;
        sb.push_back(v.e);
    endtask

    // Counts sampled edges until done is seen, bounded so a stuck DUT cannot hang the run.
    task automatic waitDone(input int start, output int n);
        n = start;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 100);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard: got done with no pending expectation, expected one", tag);
        end else begin
            e = sb.pop_front();
            checkVal({tag, " a_bcd"}, 32'(aBcd), 32'(e.aBcd));
            checkVal({tag, " a_neg"}, 32'(aNeg), 32'(e.aNeg));
            checkVal({tag, " b_bcd"}, 32'(bBcd), 32'(e.bBcd));
            checkVal({tag, " b_neg"}, 32'(bNeg), 32'(e.bNeg));
            checkVal({tag, " c_bcd"}, 32'(cBcd), 32'(e.cBcd));
            checkVal({tag, " c_neg"}, 32'(cNeg), 32'(e.cNeg));
            checkVal({tag, " err"},   32'(err),  32'(e.err));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, " busy"},  32'(busy), 0);
        checkVal({tag, " done"},  32'(done), 0);
        checkVal({tag, " a_bcd"}, 32'(aBcd), 0);
        checkVal({tag, " b_bcd"}, 32'(bBcd), 0);
        checkVal({tag, " c_bcd"}, 32'(cBcd), 0);
        checkVal({tag, " negs"},  32'({aNeg, bNeg, cNeg}), 0);
        checkVal({tag, " err"},   32'(err), 0);
    endtask

    // Main test sequence.
    initial begin
        int n;
        int lowCnt;
        int extraDone;

        // Negative values written as their 6-bit / 12-bit two's-complement patterns.
        vecs[0] = '{6'd31, 6'h20, 12'd2047, 1'b0, '{8'h31, 1'b0, 8'h32, 1'b1, 16'h2047, 1'b0, 1'b0}};
        vecs[1] = '{6'd0,  6'd0,  12'h800,  1'b1, '{8'h00, 1'b0, 8'h00, 1'b0, 16'h2048, 1'b1, 1'b1}};
        vecs[2] = '{6'h3F, 6'd9,  12'hF9D,  1'b0, '{8'h01, 1'b1, 8'h09, 1'b0, 16'h0099, 1'b1, 1'b0}};
        vecs[3] = '{6'd10, 6'h36, 12'd1000, 1'b0, '{8'h10, 1'b0, 8'h10, 1'b1, 16'h1000, 1'b0, 1'b0}};
        vecs[4] = '{6'd5,  6'd19, 12'hB2E,  1'b1, '{8'h05, 1'b0, 8'h19, 1'b0, 16'h1234, 1'b1, 1'b1}};
        vecs[5] = '{6'h2F, 6'd25, 12'd999,  1'b0, '{8'h17, 1'b1, 8'h25, 1'b0, 16'h0999, 1'b0, 1'b0}};
        vecs[6] = '{6'd0,  6'd0,  12'd0,    1'b0, '{8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0}};

        rst      = 1'b1;
        refresh  = 1'b0;
        a        = '0;
        b        = '0;
        c        = '0;
        cErr     = 1'b0;
        autoA    = 6'h3F;
        autoB    = 6'd9;
        autoC    = 12'hF9D;
        autoCErr = 1'b0;

        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] AUTO instance: continuous passes");
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!autoDone && n < 60);
        checkVal("auto first done seen", 32'(autoDone), 1);
        checkVal("auto a_bcd", 32'(autoABcd), 32'h01);
        checkVal("auto a_neg", 32'(autoANeg), 1);
        checkVal("auto b_bcd", 32'(autoBBcd), 32'h09);
        checkVal("auto b_neg", 32'(autoBNeg), 0);
        checkVal("auto c_bcd", 32'(autoCBcd), 32'h0099);
        checkVal("auto c_neg", 32'(autoCNeg), 1);
        checkVal("auto err",   32'(autoErr),  0);
        for (int k = 0; k < 2; k++) begin
            n      = 0;
            lowCnt = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
                if (!autoBusy) lowCnt++;
            end while (!autoDone && n < 60);
            checkVal("auto done period", 32'(n), 28);
            checkVal("auto busy low cycles", 32'(lowCnt), 0);
        end

        $display("[TB] table-driven passes");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            waitDone(0, n);
            checkVal($sformatf("vec%0d latency", i), 32'(n), 28);
            checkOutput($sformatf("vec%0d", i));
            @(posedge clk);
            #1;
            checkVal($sformatf("vec%0d done pulse width", i), 32'(done), 0);
            checkVal($sformatf("vec%0d idle busy", i), 32'(busy), 0);
        end

        $display("[TB] refresh and input changes during a pass");
        applyStimulus(vecs[0]);
        repeat (5) @(posedge clk);
        #1;
        checkVal("midpass outputs hold", 32'(cBcd), 32'h0000);
        a       = 6'd7;
        b       = 6'd7;
        c       = 12'd7;
        cErr    = 1'b1;
        refresh = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        refresh = 1'b0;
        waitDone(10, n);
        checkVal("midpass latency", 32'(n), 28);
        checkOutput("midpass");
        extraDone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) extraDone++;
        end
        checkVal("midpass no second done", 32'(extraDone), 0);

        $display("[TB] reset during a pass");
        applyStimulus(vecs[1]);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("midreset");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkVal("post reset idle busy", 32'(busy), 0);
        applyStimulus(vecs[4]);
        waitDone(0, n);
        checkVal("post reset latency", 32'(n), 28);
        checkOutput("post reset");

        $display("[TB] refresh held high");
        @(negedge clk);
        a       = vecs[5].a;
        b       = vecs[5].b;
        c       = vecs[5].c;
        cErr    = vecs[5].cErr;
        refresh = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(vecs[5].e);
        sb.push_back(vecs[5].e);
        waitDone(0, n);
        checkVal("held first latency", 32'(n), 28);
        checkOutput("held pass1");
        n      = 0;
        lowCnt = (busy == 1'b0) ? 1 : 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!done && !busy) lowCnt++;
        end while (!done && n < 100);
        refresh = 1'b0;
        checkVal("held done spacing", 32'(n), 29);
        checkVal("held busy low cycles", 32'(lowCnt), 1);
        checkOutput("held pass2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
